// File: rtl/cce_uc_msg_unit.sv
// Uncached message engine of the CCE. It turns LCE uc requests into memory commands and memory responses into LCE commands.
// The optional macro CCE_UC_ERR_CHECK_EN builds the sticky protocol-error checker that drives err_o.
module cce_uc_msg_unit #(
    parameter int paddr_width_p  = 40,
    parameter int data_width_p   = 64,
    parameter int lce_id_width_p = 4,
    parameter int cce_id_width_p = 2,
    parameter int max_credits_p  = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [cce_id_width_p-1:0] cce_id_i,

    input  logic                      lce_req_v_i,
    output logic                      lce_req_yumi_o,
    input  logic                      lce_req_wr_i,
    input  logic [lce_id_width_p-1:0] lce_req_src_i,
    input  logic [paddr_width_p-1:0]  lce_req_addr_i,
    input  logic [1:0]                lce_req_size_i,
    input  logic [data_width_p-1:0]   lce_req_data_i,

    output logic                      mem_cmd_v_o,
    input  logic                      mem_cmd_ready_i,
    output logic                      mem_cmd_wr_o,
    output logic [paddr_width_p-1:0]  mem_cmd_addr_o,
    output logic [1:0]                mem_cmd_size_o,
    output logic [lce_id_width_p-1:0] mem_cmd_lce_o,
    output logic [data_width_p-1:0]   mem_cmd_data_o,

    input  logic                      mem_resp_v_i,
    output logic                      mem_resp_yumi_o,
    input  logic                      mem_resp_wr_i,
    input  logic [paddr_width_p-1:0]  mem_resp_addr_i,
    input  logic [lce_id_width_p-1:0] mem_resp_lce_i,
    input  logic [data_width_p-1:0]   mem_resp_data_i,

    output logic                      lce_cmd_v_o,
    input  logic                      lce_cmd_ready_i,
    output logic                      lce_cmd_st_done_o,
    output logic [lce_id_width_p-1:0] lce_cmd_dst_o,
    output logic [cce_id_width_p-1:0] lce_cmd_src_o,
    output logic [paddr_width_p-1:0]  lce_cmd_addr_o,
    output logic [data_width_p-1:0]   lce_cmd_data_o,

    output logic                      busy_o,
    output logic                      err_o
);
    localparam int CW = $clog2(max_credits_p + 1);

    logic [CW-1:0]              credits_q, credits_d;
    logic                       full_q, full_d;
    logic                       wr_q, wr_d;
    logic [paddr_width_p-1:0]   addr_q, addr_d;
    logic [1:0]                 size_q, size_d;
    logic [lce_id_width_p-1:0]  lce_q, lce_d;
    logic [data_width_p-1:0]    data_q, data_d;
    logic [data_width_p-1:0]    rep_data;
    logic                       credits_avail;
    logic                       cred_dec;

    assign credits_avail   = credits_q < CW'(max_credits_p);
    assign lce_req_yumi_o  = lce_req_v_i & credits_avail & (~full_q | mem_cmd_ready_i);
    assign mem_resp_yumi_o = mem_resp_v_i & lce_cmd_ready_i;
    assign cred_dec        = mem_resp_yumi_o & (credits_q != '0);

    // Store data is replicated so memory sees the right bytes at any lane.
    always_comb begin
        rep_data = '0;
        if (lce_req_wr_i) begin
            case (lce_req_size_i)
                2'd0:    rep_data = {8{lce_req_data_i[7:0]}};
                2'd1:    rep_data = {4{lce_req_data_i[15:0]}};
                2'd2:    rep_data = {2{lce_req_data_i[31:0]}};
                default: rep_data = lce_req_data_i;
            endcase
        end
    end

    always_comb begin
        full_d    = full_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        size_d    = size_q;
        lce_d     = lce_q;
        data_d    = data_q;
        credits_d = credits_q;
        if (lce_req_yumi_o) begin
            full_d = 1'b1;
            wr_d   = lce_req_wr_i;
            addr_d = lce_req_addr_i;
            size_d = lce_req_size_i;
            lce_d  = lce_req_src_i;
            data_d = rep_data;
        end else if (mem_cmd_ready_i) begin
            full_d = 1'b0;
        end
        if (lce_req_yumi_o && !cred_dec) begin
            credits_d = credits_q + 1'b1;
        end else if (cred_dec && !lce_req_yumi_o) begin
            credits_d = credits_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            lce_q     <= '0;
            data_q    <= '0;
            credits_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            lce_q     <= lce_d;
            data_q    <= data_d;
            credits_q <= credits_d;
        end
    end

    assign mem_cmd_v_o    = full_q;
    assign mem_cmd_wr_o   = wr_q;
    assign mem_cmd_addr_o = addr_q;
    assign mem_cmd_size_o = size_q;
    assign mem_cmd_lce_o  = lce_q;
    assign mem_cmd_data_o = data_q;

    assign lce_cmd_v_o       = mem_resp_v_i;
    assign lce_cmd_st_done_o = mem_resp_wr_i;
    assign lce_cmd_dst_o     = mem_resp_lce_i;
    assign lce_cmd_src_o     = cce_id_i;
    assign lce_cmd_addr_o    = mem_resp_addr_i;
    assign lce_cmd_data_o    = mem_resp_wr_i ? '0 : mem_resp_data_i;
    assign busy_o            = credits_q != '0;

`ifdef CCE_UC_ERR_CHECK_EN
    // One slot per credit remembers the lce of each outstanding command.
    logic [max_credits_p-1:0]  slot_v_q, slot_v_d, match_vec;
    logic [lce_id_width_p-1:0] slot_lce_q [max_credits_p];
    logic [lce_id_width_p-1:0] slot_lce_d [max_credits_p];
    logic                      err_q, err_d;
    logic                      free_found, match_found, any_found;
    int                        free_idx, match_idx, any_idx, clr_idx;

    for (genvar gi = 0; gi < max_credits_p; gi++) begin : g_match
        assign match_vec[gi] = slot_v_q[gi] & (slot_lce_q[gi] == mem_resp_lce_i);
    end

    always_comb begin
        slot_v_d    = slot_v_q;
        slot_lce_d  = slot_lce_q;
        free_found  = 1'b0;
        match_found = 1'b0;
        any_found   = 1'b0;
        free_idx    = 0;
        match_idx   = 0;
        any_idx     = 0;
        for (int i = 0; i < max_credits_p; i++) begin
            if (!free_found && !slot_v_q[i]) begin
                free_found = 1'b1;
                free_idx   = i;
            end
            if (!match_found && match_vec[i]) begin
                match_found = 1'b1;
                match_idx   = i;
            end
            if (!any_found && slot_v_q[i]) begin
                any_found = 1'b1;
                any_idx   = i;
            end
        end
        // A mismatching response still retires a slot so slots track credits.
        clr_idx = match_found ? match_idx : any_idx;
        if (cred_dec) begin
            slot_v_d[clr_idx] = 1'b0;
        end
        if (lce_req_yumi_o) begin
            slot_v_d[free_idx]   = 1'b1;
            slot_lce_d[free_idx] = lce_req_src_i;
        end
        err_d = err_q | (mem_resp_v_i & ((credits_q == '0) | ~(|match_vec)));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_v_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < max_credits_p; i++) begin
                slot_lce_q[i] <= '0;
            end
        end else begin
            slot_v_q   <= slot_v_d;
            err_q      <= err_d;
            slot_lce_q <= slot_lce_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cce_uc_msg_unit.sv
// Directed bench for cce_uc_msg_unit: a vector table for the field paths plus hand sequences for credits and reset.
module tb_cce_uc_msg_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  cce_id = 2'd2;
    logic        lce_req_v = 0, lce_req_yumi, lce_req_wr = 0;
    logic [3:0]  lce_req_src = 0;
    logic [39:0] lce_req_addr = 0;
    logic [1:0]  lce_req_size = 0;
    logic [63:0] lce_req_data = 0;
    logic        mem_cmd_v, mem_cmd_ready = 0, mem_cmd_wr;
    logic [39:0] mem_cmd_addr;
    logic [1:0]  mem_cmd_size;
    logic [3:0]  mem_cmd_lce;
    logic [63:0] mem_cmd_data;
    logic        mem_resp_v = 0, mem_resp_yumi, mem_resp_wr = 0;
    logic [39:0] mem_resp_addr = 0;
    logic [3:0]  mem_resp_lce = 0;
    logic [63:0] mem_resp_data = 0;
    logic        lce_cmd_v, lce_cmd_ready = 0, lce_cmd_st_done;
    logic [3:0]  lce_cmd_dst;
    logic [1:0]  lce_cmd_src;
    logic [39:0] lce_cmd_addr;
    logic [63:0] lce_cmd_data;
    logic        busy, err;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int ycnt;

    always #5 clk = ~clk;

    cce_uc_msg_unit dut (
        .clk_i(clk), .reset_n_i(reset_n), .cce_id_i(cce_id),
        .lce_req_v_i(lce_req_v), .lce_req_yumi_o(lce_req_yumi), .lce_req_wr_i(lce_req_wr),
        .lce_req_src_i(lce_req_src), .lce_req_addr_i(lce_req_addr), .lce_req_size_i(lce_req_size),
        .lce_req_data_i(lce_req_data),
        .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready), .mem_cmd_wr_o(mem_cmd_wr),
        .mem_cmd_addr_o(mem_cmd_addr), .mem_cmd_size_o(mem_cmd_size), .mem_cmd_lce_o(mem_cmd_lce),
        .mem_cmd_data_o(mem_cmd_data),
        .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi), .mem_resp_wr_i(mem_resp_wr),
        .mem_resp_addr_i(mem_resp_addr), .mem_resp_lce_i(mem_resp_lce), .mem_resp_data_i(mem_resp_data),
        .lce_cmd_v_o(lce_cmd_v), .lce_cmd_ready_i(lce_cmd_ready), .lce_cmd_st_done_o(lce_cmd_st_done),
        .lce_cmd_dst_o(lce_cmd_dst), .lce_cmd_src_o(lce_cmd_src), .lce_cmd_addr_o(lce_cmd_addr),
        .lce_cmd_data_o(lce_cmd_data),
        .busy_o(busy), .err_o(err)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  lce;
        logic [39:0] addr;
        logic [63:0] data;
        logic [63:0] exp_cmd_data;
        logic [63:0] resp_data;
        logic [63:0] exp_lce_data;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s: got 0x%0h", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] size, input logic [3:0] lce,
                             input logic [39:0] addr, input logic [63:0] data);
        lce_req_v    = 1'b1;
        lce_req_wr   = wr;
        lce_req_size = size;
        lce_req_src  = lce;
        lce_req_addr = addr;
        lce_req_data = data;
    endtask

    task automatic drive_resp(input logic wr, input logic [3:0] lce,
                              input logic [39:0] addr, input logic [63:0] data);
        mem_resp_v    = 1'b1;
        mem_resp_wr   = wr;
        mem_resp_lce  = lce;
        mem_resp_addr = addr;
        mem_resp_data = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 2'd3, 4'd3,  40'h0080001000, 64'h1111,               64'h0,
                    64'hDEADBEEF,            64'hDEADBEEF};
        vecs[1] = '{1'b1, 2'd0, 4'd1,  40'h0000000040, 64'hFFFFFFFFFFFFFFA5,   64'hA5A5A5A5A5A5A5A5,
                    64'h77,                  64'h0};
        vecs[2] = '{1'b1, 2'd1, 4'd2,  40'h0000001002, 64'h1234,               64'h1234123412341234,
                    64'h99,                  64'h0};
        vecs[3] = '{1'b1, 2'd2, 4'd7,  40'h0000002004, 64'hCAFEF00D,           64'hCAFEF00DCAFEF00D,
                    64'h1,                   64'h0};
        vecs[4] = '{1'b1, 2'd3, 4'd15, 40'hFFFFFFFFF8, 64'h0123456789ABCDEF,   64'h0123456789ABCDEF,
                    64'h2,                   64'h0};
        vecs[5] = '{1'b0, 2'd0, 4'd0,  40'h0000000007, 64'hFFFF,               64'h0,
                    64'h5555AAAA5555AAAA,    64'h5555AAAA5555AAAA};

        // Reset state
        #3;
        chk("rst_mem_cmd_v", mem_cmd_v, 0);
        chk("rst_req_yumi", lce_req_yumi, 0);
        chk("rst_resp_yumi", mem_resp_yumi, 0);
        chk("rst_lce_cmd_v", lce_cmd_v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_data", mem_cmd_data, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Table: one request, drain, one matching response per vector
        for (int i = 0; i < 6; i++) begin
            mem_cmd_ready = 1'b0;
            drive_req(vecs[i].wr, vecs[i].size, vecs[i].lce, vecs[i].addr, vecs[i].data);
            #1;
            chk($sformatf("v%0d_req_yumi", i), lce_req_yumi, 1);
            tick();
            lce_req_v = 1'b0;
            #1;
            chk($sformatf("v%0d_cmd_v", i), mem_cmd_v, 1);
            chk($sformatf("v%0d_cmd_wr", i), mem_cmd_wr, vecs[i].wr);
            chk($sformatf("v%0d_cmd_addr", i), mem_cmd_addr, vecs[i].addr);
            chk($sformatf("v%0d_cmd_size", i), mem_cmd_size, vecs[i].size);
            chk($sformatf("v%0d_cmd_lce", i), mem_cmd_lce, vecs[i].lce);
            chk($sformatf("v%0d_cmd_data", i), mem_cmd_data, vecs[i].exp_cmd_data);
            chk($sformatf("v%0d_busy", i), busy, 1);
            mem_cmd_ready = 1'b1;
            tick();
            mem_cmd_ready = 1'b0;
            #1;
            chk($sformatf("v%0d_cmd_drained", i), mem_cmd_v, 0);
            lce_cmd_ready = 1'b1;
            drive_resp(vecs[i].wr, vecs[i].lce, vecs[i].addr, vecs[i].resp_data);
            #1;
            chk($sformatf("v%0d_lce_cmd_v", i), lce_cmd_v, 1);
            chk($sformatf("v%0d_resp_yumi", i), mem_resp_yumi, 1);
            chk($sformatf("v%0d_st_done", i), lce_cmd_st_done, vecs[i].wr);
            chk($sformatf("v%0d_dst", i), lce_cmd_dst, vecs[i].lce);
            chk($sformatf("v%0d_src", i), lce_cmd_src, 2);
            chk($sformatf("v%0d_lce_addr", i), lce_cmd_addr, vecs[i].addr);
            chk($sformatf("v%0d_lce_data", i), lce_cmd_data, vecs[i].exp_lce_data);
            tick();
            mem_resp_v = 1'b0;
            #1;
            chk($sformatf("v%0d_busy_done", i), busy, 0);
        end

        // Response held while the LCE network is not ready
        lce_cmd_ready = 1'b0;
        mem_cmd_ready = 1'b1;
        drive_req(1'b0, 2'd3, 4'd3, 40'h0080001000, 64'h0);
        tick();
        lce_req_v = 1'b0;
        drive_resp(1'b0, 4'd3, 40'h0080001000, 64'hDEADBEEF);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_yumi", c), mem_resp_yumi, 0);
            chk($sformatf("stall%0d_lce_v", c), lce_cmd_v, 1);
            chk($sformatf("stall%0d_busy", c), busy, 1);
            tick();
        end
        lce_cmd_ready = 1'b1;
        #1;
        chk("stall_rel_yumi", mem_resp_yumi, 1);
        chk("stall_rel_dst", lce_cmd_dst, 3);
        chk("stall_rel_data", lce_cmd_data, 64'hDEADBEEF);
        chk("stall_rel_st_done", lce_cmd_st_done, 0);
        tick();
        mem_resp_v = 1'b0;
        #1;
        chk("stall_rel_busy", busy, 0);

        // Credit limit: three back-to-back requests, only two accepted
        drive_req(1'b0, 2'd3, 4'd5, 40'h100, 64'h0);
        ycnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            ycnt += int'(lce_req_yumi);
            tick();
        end
        #1;
        chk("cred_yumi_count", ycnt, 2);
        chk("cred_stalled", lce_req_yumi, 0);
        drive_resp(1'b0, 4'd5, 40'h100, 64'h0);
        #1;
        chk("cred_resp_yumi", mem_resp_yumi, 1);
        chk("cred_req_still_blocked", lce_req_yumi, 0);
        tick();
        mem_resp_v = 1'b0;
        #1;
        chk("cred_third_accepted", lce_req_yumi, 1);
        tick();
        lce_req_v = 1'b0;
        #1;
        chk("cred_busy_full", busy, 1);
        drive_resp(1'b0, 4'd5, 40'h100, 64'h0);
        tick();
        #1;
        chk("cred_busy_one_left", busy, 1);
        tick();
        mem_resp_v = 1'b0;
        #1;
        chk("cred_busy_drained", busy, 0);

        // Same-cycle request and response at credits = 1
        drive_req(1'b0, 2'd3, 4'd5, 40'h200, 64'h0);
        tick();
        lce_req_v = 1'b0;
        #1;
        chk("same_pre_busy", busy, 1);
        drive_req(1'b0, 2'd3, 4'd5, 40'h240, 64'h0);
        drive_resp(1'b0, 4'd5, 40'h200, 64'h0);
        #1;
        chk("same_req_yumi", lce_req_yumi, 1);
        chk("same_resp_yumi", mem_resp_yumi, 1);
        tick();
        lce_req_v = 1'b0;
        mem_resp_v = 1'b0;
        #1;
        chk("same_busy_kept", busy, 1);
        drive_resp(1'b0, 4'd5, 40'h240, 64'h0);
        tick();
        mem_resp_v = 1'b0;
        #1;
        chk("same_busy_after", busy, 0);

        // Response while idle: no underflow; sticky error when checking is built
        drive_resp(1'b0, 4'd9, 40'h300, 64'h0);
        #1;
        chk("idle_resp_yumi", mem_resp_yumi, 1);
        tick();
        mem_resp_v = 1'b0;
        #1;
        chk("idle_no_underflow", busy, 0);
`ifdef CCE_UC_ERR_CHECK_EN
        chk("err_set", err, 1);
        repeat (3) tick();
        chk("err_sticky", err, 1);
`else
        chk("err_tied_low", err, 0);
`endif
        drive_req(1'b1, 2'd2, 4'd4, 40'h400, 64'h5);
        tick();
        lce_req_v = 1'b0;
        #1;
        chk("post_idle_busy", busy, 1);
        drive_resp(1'b1, 4'd4, 40'h400, 64'h0);
        tick();
        mem_resp_v = 1'b0;
        #1;
        chk("post_idle_busy_clear", busy, 0);

        // Asynchronous reset with a command and a credit in flight
        mem_cmd_ready = 1'b0;
        drive_req(1'b0, 2'd3, 4'd6, 40'h500, 64'h0);
        tick();
        lce_req_v = 1'b0;
        #1;
        chk("async_pre_cmd_v", mem_cmd_v, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_cmd_v", mem_cmd_v, 0);
        chk("async_busy", busy, 0);
        chk("async_err", err, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("async_after_cmd_v", mem_cmd_v, 0);
        chk("async_after_busy", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
